// File: rtl/jt49_pkg.sv
// jt49_pkg: shared bus-mode codes, FSM states, register indices and write-mask table
// for the AY-3-8910 CPU bus responder.
package jt49_pkg;
  localparam logic [2:0] BUS_READ  = 3'b011;
  localparam logic [2:0] BUS_WRITE = 3'b110;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LATCH = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;
  localparam logic [3:0] R_MIXER     = 4'd7;
  localparam logic [3:0] R_ENV_SHAPE = 4'd13;
  localparam logic [3:0] R_IOA       = 4'd14;
  localparam logic [3:0] R_IOB       = 4'd15;

  // 001, 100 and 111 all mean "latch address"; the remaining unlisted codes are idle
  function automatic logic [1:0] bus_decode(input logic [2:0] m);
    return m == BUS_READ ? ST_READ :
           m == BUS_WRITE ? ST_WRITE :
           m inside {3'b001, 3'b100, 3'b111} ? ST_LATCH : ST_IDLE;
  endfunction

  function automatic logic [7:0] reg_mask(input logic [3:0] a);
    return a inside {4'd1, 4'd3, 4'd5, 4'd13} ? 8'h0F :
           a inside {4'd6, 4'd8, 4'd9, 4'd10} ? 8'h1F : 8'hFF;
  endfunction
endpackage

// File: rtl/jt49_bus_sync.sv
// jt49_bus_sync: STAGES-deep per-bit synchroniser; STAGES=0 passes inputs straight through.
module jt49_bus_sync #(
  parameter int STAGES = 2,
  parameter int W      = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (STAGES == 0) begin : g_bypass
    assign q = d;
  end else begin : g_sync
    logic [W-1:0] sync_q [STAGES];
    logic [W-1:0] sync_d [STAGES];
    always_comb begin
      sync_d[0] = d;
      for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync_q <= '{default: '0};
      else        sync_q <= sync_d;
    assign q = sync_q[STAGES-1];
  end
endmodule

// File: rtl/jt49_bus_if.sv
// jt49_bus_if: AY-3-8910 BDIR/BC2/BC1 bus responder producing jt49 register writes,
// a masked shadow register file for read-back, and the two I/O port outputs.
module jt49_bus_if
  import jt49_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] CHIP_SEL    = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bdir,
  input  logic       bc2,
  input  logic       bc1,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       cpu_doe,
  output logic [3:0] core_addr,
  output logic [7:0] core_din,
  output logic       core_wr_n,
  output logic       eg_restart,
  input  logic [7:0] ioa_in,
  input  logic [7:0] iob_in,
  output logic [7:0] ioa_out,
  output logic [7:0] iob_out,
  output logic       ioa_oe,
  output logic       iob_oe
);
  logic [10:0] sync_s;
  logic [1:0]  mode, state_q, state_d;
  logic [3:0]  addr_q, addr_d, core_addr_q, core_addr_d;
  logic        sel_q, sel_d, wr_n_q, wr_n_d, eg_q, eg_d, doe_q, doe_d, do_wr, rd_en;
  logic [7:0]  wdata_q, wdata_d, core_din_q, core_din_d, dout_q, dout_d, rd_val;
  logic [7:0]  shadow_q [16];
  logic [7:0]  shadow_d [16];

  jt49_bus_sync #(.STAGES(SYNC_STAGES), .W(11)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({bdir, bc2, bc1, cpu_din}),
    .q     (sync_s)
  );

  assign mode = bus_decode(sync_s[10:8]);

  always_comb begin
    state_d     = mode;
    addr_d      = mode == ST_LATCH ? sync_s[3:0] : addr_q;
    sel_d       = mode == ST_LATCH ? sync_s[7:4] == CHIP_SEL : sel_q;
    wdata_d     = mode == ST_WRITE ? sync_s[7:0] : wdata_q;
    // commit happens on the clock the bus leaves WRITE, using the address latched before it
    do_wr       = state_q == ST_WRITE && mode != ST_WRITE && sel_q;
    wr_n_d      = !do_wr;
    eg_d        = do_wr && addr_q == R_ENV_SHAPE;
    core_addr_d = do_wr ? addr_q : core_addr_q;
    core_din_d  = do_wr ? wdata_q : core_din_q;
    shadow_d    = shadow_q;
    if (do_wr) shadow_d[addr_q] = wdata_q & reg_mask(addr_q);
    rd_en       = state_q == ST_READ && sel_q;
    rd_val      = addr_q == R_IOA && !shadow_q[R_MIXER][6] ? ioa_in :
                  addr_q == R_IOB && !shadow_q[R_MIXER][7] ? iob_in : shadow_q[addr_q];
    doe_d       = rd_en;
    dout_d      = rd_en ? rd_val : dout_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      sel_q       <= 1'b0;
      wdata_q     <= '0;
      wr_n_q      <= 1'b1;
      eg_q        <= 1'b0;
      core_addr_q <= '0;
      core_din_q  <= '0;
      shadow_q    <= '{default: '0};
      doe_q       <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      wr_n_q      <= wr_n_d;
      eg_q        <= eg_d;
      core_addr_q <= core_addr_d;
      core_din_q  <= core_din_d;
      shadow_q    <= shadow_d;
      doe_q       <= doe_d;
      dout_q      <= dout_d;
    end

  assign core_wr_n  = wr_n_q;
  assign eg_restart = eg_q;
  assign core_addr  = core_addr_q;
  assign core_din   = core_din_q;
  assign cpu_doe    = doe_q;
  assign cpu_dout   = dout_q;
  assign ioa_out    = shadow_q[R_IOA];
  assign iob_out    = shadow_q[R_IOB];
  assign ioa_oe     = shadow_q[R_MIXER][6];
  assign iob_oe     = shadow_q[R_MIXER][7];
endmodule

// File: tb/tb_jt49_bus_if.sv
// tb_jt49_bus_if: directed bus-cycle scenarios for jt49_bus_if with hand-computed expectations.
module tb_jt49_bus_if;
  localparam logic [2:0] M_IDLE  = 3'b000;
  localparam logic [2:0] M_LATCH = 3'b111;
  localparam logic [2:0] M_LAT2  = 3'b001;
  localparam logic [2:0] M_READ  = 3'b011;
  localparam logic [2:0] M_WRITE = 3'b110;

  logic       clk = 0, rst_n = 0, bdir = 0, bc2 = 0, bc1 = 0;
  logic [7:0] cpu_din = 0, ioa_in = 0, iob_in = 0;
  logic [7:0] cpu_dout, core_din, ioa_out, iob_out;
  logic [3:0] core_addr;
  logic       cpu_doe, core_wr_n, eg_restart, ioa_oe, iob_oe;
  int n_chk = 0, n_fail = 0;
  int strobes = 0, eg_cnt = 0, eg_al = 0, long_strobes = 0;
  logic [3:0] last_addr = 0;
  logic [7:0] last_din = 0;
  logic prev_wr_n = 1;

  jt49_bus_if #(.SYNC_STAGES(2), .CHIP_SEL(4'h0)) dut (
    .clk(clk), .rst_n(rst_n), .bdir(bdir), .bc2(bc2), .bc1(bc1), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_doe(cpu_doe), .core_addr(core_addr), .core_din(core_din),
    .core_wr_n(core_wr_n), .eg_restart(eg_restart), .ioa_in(ioa_in), .iob_in(iob_in),
    .ioa_out(ioa_out), .iob_out(iob_out), .ioa_oe(ioa_oe), .iob_oe(iob_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!core_wr_n) begin
      strobes++;
      last_addr = core_addr;
      last_din = core_din;
      if (eg_restart) eg_al++;
      if (!prev_wr_n) long_strobes++;
    end
    if (eg_restart) eg_cnt++;
    prev_wr_n = core_wr_n;
  end

  task automatic bus(input logic [2:0] m, input logic [7:0] d, input int n);
    {bdir, bc2, bc1} = m;
    cpu_din = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
    bus(M_LATCH, {4'h0, a}, 2);
    bus(M_WRITE, d, 2);
    bus(M_IDLE, 8'h00, 5);
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [7:0] v, output logic oe);
    bus(M_LATCH, {4'h0, a}, 2);
    bus(M_READ, 8'h00, 4);
    v = cpu_dout;
    oe = cpu_doe;
    bus(M_IDLE, 8'h00, 5);
  endtask

  task automatic test_reset();
    bus(M_WRITE, 8'hFF, 3);
    n_chk++; if (core_wr_n !== 1'b1) begin n_fail++; $display("FAIL reset_wr_n: got %b expected 1", core_wr_n); end
    n_chk++; if ({cpu_doe, eg_restart, ioa_oe, iob_oe} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {cpu_doe, eg_restart, ioa_oe, iob_oe}); end
    n_chk++; if ({cpu_dout, core_din, core_addr, ioa_out, iob_out} !== 36'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {cpu_dout, core_din, core_addr, ioa_out, iob_out}); end
    bus(M_IDLE, 8'h00, 1);
    rst_n = 1;
    bus(M_IDLE, 8'h00, 5);
    n_chk++; if (strobes !== 0) begin n_fail++; $display("FAIL reset_no_strobe: got %0d expected 0", strobes); end
  endtask

  task automatic test_write();
    int s, e;
    logic [7:0] v;
    logic oe;
    s = strobes; e = eg_cnt;
    wr_reg(4'd7, 8'h31);
    n_chk++; if (strobes - s !== 1) begin n_fail++; $display("FAIL wr_count: got %0d expected 1", strobes - s); end
    n_chk++; if (last_addr !== 4'd7 || last_din !== 8'h31) begin n_fail++; $display("FAIL wr_bus: got %h/%h expected 7/31", last_addr, last_din); end
    n_chk++; if (long_strobes !== 0 || eg_cnt !== e) begin n_fail++; $display("FAIL wr_width_eg: got %0d/%0d expected 0/%0d", long_strobes, eg_cnt, e); end
    rd_reg(4'd7, v, oe);
    n_chk++; if (v !== 8'h31 || oe !== 1'b1) begin n_fail++; $display("FAIL wr_readback: got %h/%b expected 31/1", v, oe); end
  endtask

  task automatic test_mask_read();
    logic [7:0] v;
    logic oe;
    wr_reg(4'd1, 8'hAB);
    n_chk++; if (last_din !== 8'hAB) begin n_fail++; $display("FAIL core_din_unmasked: got %h expected ab", last_din); end
    bus(M_LATCH, 8'h01, 2);
    bus(M_READ, 8'h00, 3);
    n_chk++; if (cpu_doe !== 1'b0) begin n_fail++; $display("FAIL rd_latency_early: got %b expected 0", cpu_doe); end
    bus(M_READ, 8'h00, 1);
    n_chk++; if (cpu_doe !== 1'b1 || cpu_dout !== 8'h0B) begin n_fail++; $display("FAIL rd_r1_mask: got %b/%h expected 1/0b", cpu_doe, cpu_dout); end
    bus(M_IDLE, 8'h00, 5);
    n_chk++; if (cpu_doe !== 1'b0 || cpu_dout !== 8'h0B) begin n_fail++; $display("FAIL rd_exit_hold: got %b/%h expected 0/0b", cpu_doe, cpu_dout); end
    wr_reg(4'd6, 8'hFF);
    rd_reg(4'd6, v, oe);
    n_chk++; if (v !== 8'h1F) begin n_fail++; $display("FAIL mask_r6: got %h expected 1f", v); end
    wr_reg(4'd0, 8'hFF);
    rd_reg(4'd0, v, oe);
    n_chk++; if (v !== 8'hFF) begin n_fail++; $display("FAIL mask_r0: got %h expected ff", v); end
  endtask

  task automatic test_eg_restart();
    int s, e, a;
    s = strobes; e = eg_cnt; a = eg_al;
    bus(M_LATCH, 8'h0D, 2);
    bus(M_WRITE, 8'h0E, 2);
    bus(M_IDLE, 8'h00, 5);
    bus(M_WRITE, 8'h0E, 2);
    bus(M_IDLE, 8'h00, 5);
    n_chk++; if (strobes - s !== 2 || eg_cnt - e !== 2) begin n_fail++; $display("FAIL eg_count: got %0d/%0d expected 2/2", strobes - s, eg_cnt - e); end
    n_chk++; if (eg_al - a !== 2) begin n_fail++; $display("FAIL eg_align: got %0d expected 2", eg_al - a); end
  endtask

  task automatic test_io_ports();
    logic [7:0] v;
    logic oe;
    ioa_in = 8'hC3; iob_in = 8'h99;
    wr_reg(4'd7, 8'h40);
    wr_reg(4'd14, 8'h5A);
    wr_reg(4'd15, 8'h3C);
    rd_reg(4'd14, v, oe);
    n_chk++; if (v !== 8'h5A || ioa_oe !== 1'b1 || ioa_out !== 8'h5A) begin n_fail++; $display("FAIL ioa_out_mode: got %h/%b/%h expected 5a/1/5a", v, ioa_oe, ioa_out); end
    rd_reg(4'd15, v, oe);
    n_chk++; if (v !== 8'h99 || iob_oe !== 1'b0 || iob_out !== 8'h3C) begin n_fail++; $display("FAIL iob_in_mode: got %h/%b/%h expected 99/0/3c", v, iob_oe, iob_out); end
    wr_reg(4'd7, 8'h80);
    rd_reg(4'd15, v, oe);
    n_chk++; if (v !== 8'h3C || iob_oe !== 1'b1) begin n_fail++; $display("FAIL iob_out_mode: got %h/%b expected 3c/1", v, iob_oe); end
    wr_reg(4'd7, 8'h00);
    rd_reg(4'd14, v, oe);
    n_chk++; if (v !== 8'hC3 || ioa_oe !== 1'b0) begin n_fail++; $display("FAIL ioa_in_mode: got %h/%b expected c3/0", v, ioa_oe); end
  endtask

  task automatic test_deselect();
    int s;
    logic [7:0] v;
    logic oe;
    s = strobes;
    bus(M_LATCH, 8'h17, 2);
    bus(M_WRITE, 8'hFF, 2);
    bus(M_IDLE, 8'h00, 5);
    n_chk++; if (strobes !== s) begin n_fail++; $display("FAIL desel_strobe: got %0d expected %0d", strobes, s); end
    rd_reg(4'd7, v, oe);
    n_chk++; if (v !== 8'h00) begin n_fail++; $display("FAIL desel_r7: got %h expected 00", v); end
    bus(M_LATCH, 8'h17, 2);
    bus(M_READ, 8'h00, 4);
    n_chk++; if (cpu_doe !== 1'b0) begin n_fail++; $display("FAIL desel_doe: got %b expected 0", cpu_doe); end
    bus(M_IDLE, 8'h00, 5);
  endtask

  task automatic test_back_to_back();
    int s;
    logic [7:0] v;
    logic oe;
    s = strobes;
    bus(M_LATCH, 8'h02, 2);
    bus(M_WRITE, 8'h55, 1);
    bus(M_LAT2, 8'h03, 2);
    bus(M_IDLE, 8'h00, 5);
    n_chk++; if (strobes - s !== 1 || last_addr !== 4'd2 || last_din !== 8'h55) begin n_fail++; $display("FAIL b2b_strobe: got %0d/%h/%h expected 1/2/55", strobes - s, last_addr, last_din); end
    rd_reg(4'd2, v, oe);
    n_chk++; if (v !== 8'h55) begin n_fail++; $display("FAIL b2b_r2: got %h expected 55", v); end
    rd_reg(4'd3, v, oe);
    n_chk++; if (v !== 8'h00) begin n_fail++; $display("FAIL b2b_r3: got %h expected 00", v); end
  endtask

  task automatic test_reset_mid_write();
    int s;
    logic [7:0] v;
    logic oe;
    wr_reg(4'd7, 8'hC0);
    n_chk++; if (ioa_oe !== 1'b1 || iob_oe !== 1'b1 || ioa_out !== 8'h5A) begin n_fail++; $display("FAIL pre_reset: got %b/%b/%h expected 1/1/5a", ioa_oe, iob_oe, ioa_out); end
    s = strobes;
    bus(M_LATCH, 8'h00, 2);
    bus(M_WRITE, 8'h22, 4);
    rst_n = 0;
    bus(M_IDLE, 8'h00, 3);
    n_chk++; if ({core_wr_n, cpu_doe, eg_restart, ioa_oe, iob_oe} !== 5'b10000) begin n_fail++; $display("FAIL mid_reset_flags: got %b expected 10000", {core_wr_n, cpu_doe, eg_restart, ioa_oe, iob_oe}); end
    n_chk++; if ({cpu_dout, core_din, core_addr, ioa_out, iob_out} !== 36'h0) begin n_fail++; $display("FAIL mid_reset_data: got %h expected 0", {cpu_dout, core_din, core_addr, ioa_out, iob_out}); end
    rst_n = 1;
    bus(M_IDLE, 8'h00, 6);
    n_chk++; if (strobes !== s) begin n_fail++; $display("FAIL reset_discard: got %0d expected %0d", strobes, s); end
    rd_reg(4'd0, v, oe);
    n_chk++; if (v !== 8'h00 || oe !== 1'b1) begin n_fail++; $display("FAIL reset_r0: got %h/%b expected 00/1", v, oe); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_mask_read();
    test_eg_restart();
    test_io_ports();
    test_deselect();
    test_back_to_back();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
